// File: rtl/cpu10_ctrl_pkg.sv
// Shared encodings for the 10-bit CPU control path: opcodes, ALU codes,
// next-PC selects, FSM states and instruction classes.
package cpu10_ctrl_pkg;

  // Opcodes (instr[9:6])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_NAND = 4'b0011;
  localparam logic [3:0] OP_SLR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_J    = 4'b1011;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;
  localparam logic [2:0] ALU_SLR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_HALT = 3'b110;

  // Next-PC selects
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_J       = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: instruction class plus the ALU code used
// during EXECUTE.
module op_decoder
  import cpu10_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output op_class_t  op_class,
  output logic [2:0] alu_op
);

  // Classify the latched opcode and pick its ALU operation
  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_NAND, OP_SLR, OP_SLL: begin
        op_class = CLS_R;
        alu_op   = op[2:0];
      end
      OP_HALT: begin
        op_class = CLS_HALT;
        alu_op   = ALU_HALT;
      end
      OP_ADDI: op_class = CLS_ADDI;
      OP_LW:   op_class = CLS_LW;
      OP_SW:   op_class = CLS_SW;
      OP_BEQ: begin
        op_class = CLS_BEQ;
        alu_op   = ALU_SUB;
      end
      OP_J:    op_class = CLS_J;
      default: begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 10-bit CPU: fetch handshake, decode,
// execute/memory/writeback strobes, next-PC select and a saturating
// retired-instruction counter. Outputs decode combinationally from the
// state register, the latched opcode and the handshake inputs.
module multicycle_control_unit
  import cpu10_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_zero,
  input  logic             alu_halt,
  output logic             imem_re,
  output logic             ir_we,
  output logic [2:0]       alu_ctrl,
  output logic             alu_src_imm,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             rf_dst_rt,
  output logic             wb_mem,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [3:0]       op_q_r;
  logic [CNT_W-1:0] retired_r;
  logic             retire_s;
  op_class_t        op_class_s;
  logic [2:0]       dec_alu_s;

  // Operand/address fields are consumed by the datapath, not by control.
  logic             unused_fields_s;
  assign unused_fields_s = ^instr[5:0];

  op_decoder u_op_decoder (
    .op       (op_q_r),
    .op_class (op_class_s),
    .alu_op   (dec_alu_s)
  );

  // State register, opcode latch and saturating retired counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      op_q_r    <= 4'd0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (ir_we) begin
        op_q_r <= instr[9:6];
      end
      if (retire_s && (retired_r != CNT_MAX)) begin
        retired_r <= retired_r + CNT_ONE;
      end
    end
  end

  assign retired = retired_r;

  // Next-state and strobe decode; reset forces every strobe low at once
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    imem_re      = 1'b0;
    ir_we        = 1'b0;
    alu_ctrl     = ALU_ADD;
    alu_src_imm  = 1'b0;
    dmem_re      = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    rf_dst_rt    = 1'b0;
    wb_mem       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_INC;
    illegal_op   = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      state_next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          imem_re = 1'b1;
          if (imem_ready) begin
            ir_we        = 1'b1;
            state_next_s = DECODE;
          end else begin
            state_next_s = FETCH;
          end
        end
        DECODE: begin
          if (op_class_s == CLS_ILLEGAL) begin
            illegal_op   = 1'b1;
            pc_we        = 1'b1;
            pc_sel       = PC_INC;
            state_next_s = FETCH;
          end else begin
            state_next_s = EXECUTE;
          end
        end
        EXECUTE: begin
          case (op_class_s)
            CLS_R: begin
              alu_ctrl     = dec_alu_s;
              state_next_s = WRITEBACK;
            end
            CLS_ADDI: begin
              alu_ctrl     = dec_alu_s;
              alu_src_imm  = 1'b1;
              state_next_s = WRITEBACK;
            end
            CLS_LW, CLS_SW: begin
              alu_ctrl     = dec_alu_s;
              alu_src_imm  = 1'b1;
              state_next_s = MEM;
            end
            CLS_BEQ: begin
              alu_ctrl     = dec_alu_s;
              pc_we        = 1'b1;
              retire_s     = 1'b1;
              state_next_s = FETCH;
              if (alu_zero) begin
                pc_sel = PC_BR;
              end else begin
                pc_sel = PC_INC;
              end
            end
            CLS_J: begin
              pc_we        = 1'b1;
              pc_sel       = PC_JMP;
              retire_s     = 1'b1;
              state_next_s = FETCH;
            end
            CLS_HALT: begin
              alu_ctrl = dec_alu_s;
              if (alu_halt) begin
                retire_s     = 1'b1;
                state_next_s = HALTED;
              end else begin
                // ALU refused the halt: treat as a bad instruction and skip it
                illegal_op   = 1'b1;
                pc_we        = 1'b1;
                pc_sel       = PC_INC;
                state_next_s = FETCH;
              end
            end
            default: begin
              state_next_s = FETCH;
            end
          endcase
        end
        MEM: begin
          // Address operands stay selected for the whole access
          alu_ctrl    = ALU_ADD;
          alu_src_imm = 1'b1;
          if (op_class_s == CLS_SW) begin
            dmem_we = 1'b1;
            if (dmem_ready) begin
              pc_we        = 1'b1;
              pc_sel       = PC_INC;
              retire_s     = 1'b1;
              state_next_s = FETCH;
            end else begin
              state_next_s = MEM;
            end
          end else begin
            dmem_re = 1'b1;
            if (dmem_ready) begin
              state_next_s = WRITEBACK;
            end else begin
              state_next_s = MEM;
            end
          end
        end
        WRITEBACK: begin
          rf_we        = 1'b1;
          pc_we        = 1'b1;
          pc_sel       = PC_INC;
          retire_s     = 1'b1;
          state_next_s = FETCH;
          if ((op_class_s == CLS_ADDI) || (op_class_s == CLS_LW)) begin
            rf_dst_rt = 1'b1;
          end else begin
            rf_dst_rt = 1'b0;
          end
          if (op_class_s == CLS_LW) begin
            wb_mem = 1'b1;
          end else begin
            wb_mem = 1'b0;
          end
        end
        HALTED: begin
          halted       = 1'b1;
          state_next_s = HALTED;
        end
        default: begin
          state_next_s = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the stimulus process pushes the expected per-instruction
// behaviour from an opcode-level reference model; a monitor summarises each
// instruction as the DUT presents it (pc_we or halted) and compares.
module tb_multicycle_control_unit;

  localparam int CW      = 4;
  localparam int CNT_SAT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    instr = 10'd0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          alu_zero = 1'b0;
  logic          alu_halt = 1'b0;
  logic          imem_re, ir_we, alu_src_imm, dmem_re, dmem_we, rf_we;
  logic          rf_dst_rt, wb_mem, pc_we, illegal_op, halted;
  logic [2:0]    alu_ctrl;
  logic [1:0]    pc_sel;
  logic [CW-1:0] retired;

  multicycle_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_zero(alu_zero), .alu_halt(alu_halt),
    .imem_re(imem_re), .ir_we(ir_we), .alu_ctrl(alu_ctrl),
    .alu_src_imm(alu_src_imm), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .rf_we(rf_we), .rf_dst_rt(rf_dst_rt), .wb_mem(wb_mem), .pc_we(pc_we),
    .pc_sel(pc_sel), .illegal_op(illegal_op), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len; int rfw; int dre; int dwe; int ill;
    int alu; int imm; int wbm; int dst; int psel; int hlt; int ret;
  } txn_t;

  txn_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_ret = 0;
  int   excl_bad = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: behaviour of one instruction from its opcode and waits
  function automatic txn_t model(input logic [9:0] ins, input int iw,
                                 input int dw, input bit z, input bit h);
    txn_t e;
    int op;
    bit ret_inc;
    op = int'(ins[9:6]);
    e = '{default: 0};
    e.ret = model_ret;
    ret_inc = 1'b1;
    if (op <= 5) begin
      e.len = iw + 4; e.rfw = 1; e.alu = op;
    end else if (op == 6) begin
      e.alu = 6;
      if (h) begin e.len = iw + 4; e.hlt = 1; end
      else begin e.len = iw + 3; e.ill = 1; ret_inc = 1'b0; end
    end else if (op == 7) begin
      e.len = iw + 4; e.rfw = 1; e.imm = 1; e.dst = 1;
    end else if (op == 8) begin
      e.len = iw + dw + 5; e.rfw = 1; e.imm = 1; e.dst = 1; e.wbm = 1; e.dre = dw + 1;
    end else if (op == 9) begin
      e.len = iw + dw + 4; e.imm = 1; e.dwe = dw + 1;
    end else if (op == 10) begin
      e.len = iw + 3; e.alu = 1; e.psel = z ? 1 : 0;
    end else if (op == 11) begin
      e.len = iw + 3; e.psel = 2;
    end else begin
      e.len = iw + 2; e.ill = 1; ret_inc = 1'b0;
    end
    if (ret_inc && model_ret < CNT_SAT) model_ret = model_ret + 1;
    return e;
  endfunction

  // Drive one instruction through fetch (and data memory) handshakes
  task automatic issue(input logic [9:0] ins, input int iw, input int dw,
                       input bit z, input bit h);
    int bud;
    exp_q.push_back(model(ins, iw, dw, z, h));
    bud = 0;
    while (!imem_re && bud < 50) begin @(posedge clk); #1; bud++; end
    chk("imem_re_wait", int'(imem_re), 1);
    instr = ins; alu_zero = z; alu_halt = h;
    for (int k = 0; k <= iw; k++) begin
      imem_ready = (k == iw);
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    if (ins[9:6] == 4'd8 || ins[9:6] == 4'd9) begin
      bud = 0;
      while (!(dmem_re || dmem_we) && bud < 50) begin @(posedge clk); #1; bud++; end
      chk("dmem_wait", int'(dmem_re || dmem_we), 1);
      for (int k = 0; k <= dw; k++) begin
        dmem_ready = (k == dw);
        @(posedge clk); #1;
      end
      dmem_ready = 1'b0;
    end
  endtask

  // Monitor: summarise each instruction and compare against the scoreboard
  txn_t a;
  bit   active = 1'b0;
  int   ir_idx = 0;
  always @(negedge clk) begin
    if (dmem_re && dmem_we) excl_bad++;
    if (rf_we && dmem_we) excl_bad++;
    if (rst || !mon_en) begin
      active = 1'b0;
    end else begin
      if (!active && imem_re) begin
        active = 1'b1; a = '{default: 0}; a.ret = int'(retired); ir_idx = 0;
      end
      if (active) begin
        a.len = a.len + 1;
        if (ir_we) ir_idx = a.len;
        if (ir_idx > 0 && a.len == ir_idx + 2) begin
          a.alu = int'(alu_ctrl); a.imm = int'(alu_src_imm);
        end
        if (rf_we) begin a.rfw = a.rfw + 1; a.wbm = int'(wb_mem); a.dst = int'(rf_dst_rt); end
        if (dmem_re) a.dre = a.dre + 1;
        if (dmem_we) a.dwe = a.dwe + 1;
        if (illegal_op) a.ill = a.ill + 1;
        if (pc_we || halted) begin
          a.psel = pc_we ? int'(pc_sel) : 0;
          a.hlt = int'(halted);
          active = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", 1, 0);
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            chk("latency", a.len, e.len);       chk("rf_we_cycles", a.rfw, e.rfw);
            chk("dmem_re_cycles", a.dre, e.dre); chk("dmem_we_cycles", a.dwe, e.dwe);
            chk("illegal_pulses", a.ill, e.ill); chk("exec_alu_ctrl", a.alu, e.alu);
            chk("exec_alu_src_imm", a.imm, e.imm); chk("wb_mem", a.wbm, e.wbm);
            chk("rf_dst_rt", a.dst, e.dst);     chk("pc_sel", a.psel, e.psel);
            chk("halted_end", a.hlt, e.hlt);    chk("retired_start", a.ret, e.ret);
          end
        end
      end
    end
  end

  initial begin
    int bud;
    logic [9:0] ins;
    int op;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_re", int'(imem_re), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_alu_ctrl", int'(alu_ctrl), 0);
    chk("rst_halted", int'(halted), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_imem_re", int'(imem_re), 1);

    // Directed cases
    issue(10'b0000_01_10_11, 0, 0, 1'b0, 1'b0);   // ADD
    issue(10'b1000_00_01_11, 0, 3, 1'b0, 1'b0);   // LW, 3 wait cycles
    issue(10'b1010_01_01_10, 0, 0, 1'b1, 1'b0);   // BEQ taken
    issue(10'b1010_01_01_10, 0, 0, 1'b0, 1'b0);   // BEQ not taken
    issue(10'b0110_000000,   0, 0, 1'b0, 1'b0);   // HALT refused
    issue(10'b1110_000000,   0, 0, 1'b0, 1'b0);   // illegal
    issue(10'b1001_11_00_01, 1, 2, 1'b0, 1'b0);   // SW with waits
    issue(10'b1011_101010,   2, 0, 1'b1, 1'b0);   // J

    // Randomized stream (runs the counter into saturation)
    for (int n = 0; n < 150; n++) begin
      ins = 10'($urandom_range(0, 1023));
      op  = int'(ins[9:6]);
      issue(ins, $urandom_range(0, 2), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), (op == 6) ? 1'b0 : 1'($urandom_range(0, 1)));
    end

    // HALT accepted: absorbing halted state
    issue(10'b0110_000000, 0, 0, 1'b0, 1'b1);
    bud = 0;
    while (!halted && bud < 20) begin @(posedge clk); #1; bud++; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("halted_hold", int'(halted), 1);
      chk("halted_imem_re", int'(imem_re), 0);
    end
    chk("halted_retired", int'(retired), model_ret);

    // Reset mid-MEM of a store
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1; rst = 1'b0; #1;
    model_ret = 0;
    bud = 0;
    while (!imem_re && bud < 20) begin @(posedge clk); #1; bud++; end
    instr = 10'b1001_00_00_00; imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    bud = 0;
    while (!dmem_we && bud < 20) begin @(posedge clk); #1; bud++; end
    chk("sw_dmem_we_before_rst", int'(dmem_we), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dmem_we", int'(dmem_we), 0);
    chk("async_rst_retired", int'(retired), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("release_imem_re", int'(imem_re), 1);
    @(posedge clk); #1;
    chk("release_fetch_hold", int'(imem_re), 1);

    chk("queue_drained", exp_q.size(), 0);
    chk("exclusive_strobes", excl_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
